// File: rtl/pb_debounce_port.sv
// Push-button synchroniser/debouncer with sticky press/release flags and a button-0 press counter, packed into a 32-bit CPU input word.
// Latency: an accepted level change appears on port_in DEBOUNCE_CYCLES+2 edges after the raw pin settles; a flag clear takes effect on the sampling edge.
// Backpressure: none; the CPU reads port_in at will and event_clr clears flags at any time, with a coincident set taking priority.
//
// Ports:
//   clk        system clock (PLL output)
//   reset      synchronous, active-high reset
//   pb_n       raw asynchronous buttons, active-low
//   event_clr  per-button clear for the press/release flags
//   port_in    packed status: [NUM_BTN-1:0] stable, [8+:NUM_BTN] press flags,
//              [16+:NUM_BTN] release flags, [31:24] button-0 press count
//
// Optional feature macro: PB_DEBOUNCE_RELEASE_EVENT_EN builds the release
// flags; without it port_in[23:16] is constant zero.

module pb_debounce_port #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] pb_n,
  input  logic [NUM_BTN-1:0] event_clr,
  output logic [31:0]        port_in
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [NUM_BTN-1:0]   r_s1;
  logic [NUM_BTN-1:0]   r_s2;
  logic [NUM_BTN-1:0]   r_stable;
  logic [CNT_WIDTH-1:0] r_cnt [NUM_BTN];
  logic [NUM_BTN-1:0]   r_press_evt;
  logic [7:0]           r_press_cnt;

  logic [NUM_BTN-1:0]   w_accept;
  logic [NUM_BTN-1:0]   w_press;
  logic [31:0]          w_port;

  // A button is accepted when its synchronised level has disagreed with the
  // accepted level for the full qualification window.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      w_accept[i] = (r_s2[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX);
    end
  end

  assign w_press = w_accept & r_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1        <= '0;
      r_s2        <= '0;
      r_stable    <= '0;
      r_press_evt <= '0;
      r_press_cnt <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1 <= ~pb_n;
      r_s2 <= r_s1;
      for (int i = 0; i < NUM_BTN; i++) begin
        // Any sample agreeing with the accepted level restarts qualification,
        // so bounces shorter than the window never reach r_stable.
        if (r_s2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_stable[i] <= r_s2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
      // Set beats clear so a press landing on a clear edge is not lost.
      r_press_evt <= (r_press_evt & ~event_clr) | w_press;
      if (w_press[0]) begin
        r_press_cnt <= r_press_cnt + 8'd1;
      end
    end
  end

`ifdef PB_DEBOUNCE_RELEASE_EVENT_EN
  logic [NUM_BTN-1:0] r_rel_evt;
  logic [NUM_BTN-1:0] w_release;

  assign w_release = w_accept & ~r_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rel_evt <= '0;
    end else begin
      r_rel_evt <= (r_rel_evt & ~event_clr) | w_release;
    end
  end
`endif

  always_comb begin
    w_port                = '0;
    w_port[NUM_BTN-1:0]   = r_stable;
    w_port[8 +: NUM_BTN]  = r_press_evt;
`ifdef PB_DEBOUNCE_RELEASE_EVENT_EN
    w_port[16 +: NUM_BTN] = r_rel_evt;
`endif
    w_port[31:24]         = r_press_cnt;
  end

  assign port_in = w_port;

endmodule

// File: tb/tb_pb_debounce_port.sv
module tb_pb_debounce_port;

  localparam int NB = 4;
  localparam int D  = 4;

  logic          clk;
  logic          reset;
  logic [NB-1:0] pb_n;
  logic [NB-1:0] event_clr;
  logic [31:0]   port_in;

  int n_checks = 0;
  int n_fail   = 0;

  pb_debounce_port #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(D),
    .CNT_WIDTH      (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pb_n     (pb_n),
    .event_clr(event_clr),
    .port_in  (port_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: a level is accepted when the last D pressed/released
  // samples seen by the debouncer (raw pin delayed by two edges) all agree
  // and differ from the accepted level. m_hist[k] holds the pressed level
  // sampled k+1 edges ago; reset makes the whole history read as released.
  // ---------------------------------------------------------------------
  logic [NB-1:0] m_hist [0:D];
  logic [NB-1:0] m_stable, m_press, m_rel, set_p, set_r;
  logic [7:0]    m_cnt;
  bit            m_valid = 0;
  bit            same;

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= D; k++) m_hist[k] = '0;
      m_stable = '0;
      m_press  = '0;
      m_rel    = '0;
      m_cnt    = '0;
      m_valid  = 1;
    end else if (m_valid) begin
      set_p = '0;
      set_r = '0;
      for (int i = 0; i < NB; i++) begin
        same = 1;
        for (int k = 2; k <= D; k++) if (m_hist[k][i] != m_hist[1][i]) same = 0;
        if (same && m_hist[1][i] != m_stable[i]) begin
          m_stable[i] = m_hist[1][i];
          if (m_hist[1][i]) set_p[i] = 1'b1;
          else              set_r[i] = 1'b1;
        end
      end
      if (set_p[0]) m_cnt = m_cnt + 8'd1;
      m_press = (m_press & ~event_clr) | set_p;
      m_rel   = (m_rel & ~event_clr) | set_r;
      for (int k = D; k >= 1; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = ~pb_n;
    end
  end

  function automatic logic [31:0] m_pack();
`ifdef PB_DEBOUNCE_RELEASE_EVENT_EN
    return {m_cnt, 4'h0, m_rel, 4'h0, m_press, 4'h0, m_stable};
`else
    return {m_cnt, 4'h0, 4'h0, 4'h0, m_press, 4'h0, m_stable};
`endif
  endfunction

  always @(negedge clk) begin
    if (m_valid) check("model", port_in, m_pack());
  end

  // ---------------------------------------------------------------------
  // Stimulus: inputs change 1 time unit after a rising edge.
  // ---------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Step once while jittering buttons 1..3 and the clears (button 0 untouched).
  task automatic rstep();
    logic [2:0] r;
    r = 3'($urandom);
    pb_n[3:1] = r;
    event_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
    step(1);
  endtask

  logic [31:0] exp_rel;

  initial begin
    reset     = 1'b1;
    pb_n      = 4'hF;
    event_clr = 4'h0;

    // Reset held three cycles with buttons released.
    step(3);
    reset = 1'b0;
    check("reset_state", port_in, 32'h0);
    for (int k = 0; k < 20; k++) begin
      step(1);
      check("idle_after_reset", port_in, 32'h0);
    end

    // Button 0 pressed and held: accepted on edge 6.
    pb_n[0] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      check("press_latency_quiet", port_in, 32'h0);
    end
    step(1);
    check("press_accept_edge6", port_in, 32'h0100_0101);

    // Bounces on button 1 never qualify.
    pb_n[1] = 1'b0; step(3); pb_n[1] = 1'b1; step(10);
    check("bounce_3low", port_in, 32'h0100_0101);
    pb_n[1] = 1'b0; step(3); pb_n[1] = 1'b1; step(1);
    pb_n[1] = 1'b0; step(3); pb_n[1] = 1'b1; step(10);
    check("bounce_3_1_3", port_in, 32'h0100_0101);

    // One-cycle clear of press flag 0.
    event_clr[0] = 1'b1; step(1); event_clr[0] = 1'b0;
    check("clear_press0", port_in, 32'h0100_0001);

    // Clear coinciding with the accepting edge of button 2: set wins.
    pb_n[2] = 1'b0; step(5);
    event_clr[2] = 1'b1; step(1); event_clr[2] = 1'b0;
    check("set_beats_clear", port_in, 32'h0100_0405);

    // Release button 0.
    pb_n[0] = 1'b1; step(5);
    check("release_quiet", port_in, 32'h0100_0405);
    step(1);
`ifdef PB_DEBOUNCE_RELEASE_EVENT_EN
    exp_rel = 32'h0101_0404;
`else
    exp_rel = 32'h0100_0404;
`endif
    check("release_accept_edge6", port_in, exp_rel);

    // Reset in the middle of a count with button 0 held.
    step(8);
    pb_n = 4'hE; step(4);
    reset = 1'b1; step(1); reset = 1'b0;
    check("reset_mid_count", port_in, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      step(1);
      check("requalify_quiet", port_in, 32'h0);
    end
    step(1);
    check("requalify_edge6", port_in, 32'h0100_0101);

    // Press counter wrap: 256 presses return to zero, the next reads one.
    pb_n = 4'hF;
    reset = 1'b1; step(2); reset = 1'b0;
    for (int p = 0; p < 256; p++) begin
      pb_n[0] = 1'b0;
      repeat ($urandom_range(6, 9)) rstep();
      pb_n[0] = 1'b1;
      repeat ($urandom_range(6, 9)) rstep();
    end
    event_clr = 4'h0;
    check("press_cnt_wrap256", {24'h0, port_in[31:24]}, 32'h0);
    pb_n[0] = 1'b0; step(6);
    check("press_cnt_257", {24'h0, port_in[31:24]}, 32'h1);

    // Free-running random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NB; i++) begin
        if ($urandom_range(0, 5) == 0) pb_n[i] = ~pb_n[i];
      end
      event_clr = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
      reset     = ($urandom_range(0, 399) == 0);
      step(1);
    end
    reset = 1'b0;
    event_clr = 4'h0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
